// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory (including the memory-mapped tube
// registers) between the MEM-stage CPU port and a DMA/debug port.
// The CPU has priority. A starvation counter guarantees that a waiting DMA
// request eventually wins. A locked DMA burst owns the memory for at most
// BURST_MAX beats.
//
// Ports
//   clk, reset (async, active-low)
//   cpu_read/cpu_write/cpu_addr/cpu_wdata -> cpu_rdata, cpu_stall
//   dma_req/dma_we/dma_lock/dma_addr/dma_wdata -> dma_gnt, dma_rdata, dma_rvalid
//   mem_read/mem_write/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//   dma_owner: high while a locked burst owns the memory
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        dma_owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [7:0] BURST_LIM  = 8'(BURST_MAX);

  typedef enum logic {CPU_OWN, DMA_OWN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  beat_inc;
  logic [31:0] dma_rdata_q;
  logic        dma_rvalid_q;
  logic        cpu_req;
  logic        dma_gnt_w;
  logic        cpu_gnt_w;

  // Grant decision. Reset gates both grants so all memory strobes drop at once.
  always_comb begin
    cpu_req   = cpu_read | cpu_write;
    dma_gnt_w = 1'b0;
    if (reset) begin
      if (state_q == DMA_OWN) dma_gnt_w = dma_req;
      else                    dma_gnt_w = dma_req & (~cpu_req | (starve_q == STARVE_LIM));
    end
    // A CPU that does not lose to the DMA is granted, including the cycle in
    // which a burst ends because dma_req dropped.
    cpu_gnt_w = reset & cpu_req & ~dma_gnt_w;
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    beat_inc = beat_q + 8'd1;

    if (dma_req && !dma_gnt_w) starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
    else                       starve_d = '0;

    case (state_q)
      CPU_OWN: begin
        // The opening beat counts as beat 1; a one-beat burst never enters DMA_OWN.
        if (dma_gnt_w && dma_lock && BURST_LIM != 8'd1) begin
          state_d = DMA_OWN;
          beat_d  = 8'd1;
        end
      end
      DMA_OWN: begin
        // Unlock and forced release can coincide; both take the same exit.
        if (!dma_req || !dma_lock || beat_inc == BURST_LIM) begin
          state_d = CPU_OWN;
          beat_d  = '0;
        end else begin
          beat_d  = beat_inc;
        end
      end
      default: begin
        state_d = CPU_OWN;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CPU_OWN;
      starve_q     <= '0;
      beat_q       <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      beat_q       <= beat_d;
      dma_rvalid_q <= dma_gnt_w & ~dma_we;
      if (dma_gnt_w && !dma_we) dma_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    mem_read  = dma_gnt_w ? ~dma_we : (cpu_gnt_w & cpu_read);
    mem_write = dma_gnt_w ?  dma_we : (cpu_gnt_w & cpu_write);
    mem_addr  = dma_gnt_w ? dma_addr  : cpu_addr;
    mem_wdata = dma_gnt_w ? dma_wdata : cpu_wdata;
    cpu_rdata = cpu_gnt_w ? mem_rdata : '0;
    cpu_stall = cpu_req & dma_gnt_w;
    dma_gnt   = dma_gnt_w;
    dma_owner = reset & (state_q == DMA_OWN);
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int BURST_MAX    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt, dma_rvalid;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        dma_owner;

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dma_owner(dma_owner)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT (64 words, asynchronous read).
  logic [31:0] hw_mem [64];
  logic [31:0] ref_mem [64];
  assign mem_rdata = hw_mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) hw_mem[mem_addr[7:2]] <= mem_wdata;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a count of lost cycles, burst flag and beats taken.
  bit          m_burst;
  int          m_beats, m_lost;
  bit          m_rv_pend;
  logic [31:0] m_rdata;
  bit          m_stall;

  always @(negedge clk) begin
    bit creq, dg, cg;
    if (!reset) begin
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_dma_owner", dma_owner, 0);
      chk("rst_dma_rvalid", dma_rvalid, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      m_burst = 0; m_beats = 0; m_lost = 0; m_rv_pend = 0; m_rdata = '0; m_stall = 0;
    end else begin
      creq = cpu_read | cpu_write;
      dg   = m_burst ? dma_req : (dma_req && (!creq || m_lost >= STARVE_LIMIT));
      cg   = creq && !dg;
      chk("dma_gnt", dma_gnt, dg);
      chk("cpu_stall", cpu_stall, creq && dg);
      chk("mem_read", mem_read, dg ? !dma_we : (cg && cpu_read));
      chk("mem_write", mem_write, dg ? dma_we : (cg && cpu_write));
      chk("mem_addr", mem_addr, dg ? dma_addr : cpu_addr);
      chk("mem_wdata", mem_wdata, dg ? dma_wdata : cpu_wdata);
      chk("cpu_rdata", cpu_rdata, cg ? ref_mem[cpu_addr[7:2]] : 32'h0);
      chk("dma_owner", dma_owner, m_burst);
      chk("dma_rvalid", dma_rvalid, m_rv_pend);
      chk("dma_rdata", dma_rdata, m_rdata);
      m_stall   = creq && dg;
      m_rv_pend = dg && !dma_we;
      if (m_rv_pend) m_rdata = ref_mem[dma_addr[7:2]];
      if (dg && dma_we)         ref_mem[dma_addr[7:2]] = dma_wdata;
      else if (cg && cpu_write) ref_mem[cpu_addr[7:2]] = cpu_wdata;
      m_lost = (dma_req && !dg) ? ((m_lost + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_lost + 1) : 0;
      if (m_burst) begin
        if (!dma_req) begin
          m_burst = 0; m_beats = 0;
        end else begin
          m_beats++;
          if (!dma_lock || m_beats == BURST_MAX) begin m_burst = 0; m_beats = 0; end
        end
      end else if (dg && dma_lock && BURST_MAX > 1) begin
        m_burst = 1; m_beats = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_read = 0; cpu_write = 0; dma_req = 0; dma_lock = 0; dma_we = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      hw_mem[i]  = 32'hA000_0000 | i;
      ref_mem[i] = 32'hA000_0000 | i;
    end
    reset = 0; idle();
    cpu_addr = 32'h0; cpu_wdata = 32'h0; dma_addr = 32'h0; dma_wdata = 32'h0;

    // Reset holds everything off even with requests present.
    cpu_read = 1; dma_req = 1;
    step(); step();
    @(negedge clk);
    chk("lit_rst_gnt", dma_gnt, 0);
    chk("lit_rst_stall", cpu_stall, 0);
    chk("lit_rst_mread", mem_read, 0);
    step();
    reset = 1; dma_req = 0;
    @(negedge clk);
    chk("lit_rel_mread", mem_read, 1);
    chk("lit_rel_owner", dma_owner, 0);

    // CPU-only write.
    step();
    cpu_read = 0; cpu_write = 1; cpu_addr = 32'h4000_0010; cpu_wdata = 32'h5;
    @(negedge clk);
    chk("lit_cpu_mwrite", mem_write, 1);
    chk("lit_cpu_maddr", mem_addr, 32'h4000_0010);
    chk("lit_cpu_stall", cpu_stall, 0);
    step(); idle(); step();

    // Starvation: CPU wins 4 cycles, DMA wins the 5th, rvalid on the 6th.
    cpu_read = 1; cpu_addr = 32'h100; dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("lit_starve_gnt", dma_gnt, (c == 4) ? 1 : 0);
      chk("lit_starve_stall", cpu_stall, (c == 4) ? 1 : 0);
      if (c == 5) begin
        chk("lit_starve_rvalid", dma_rvalid, 1);
        chk("lit_starve_rdata", dma_rdata, 32'hA000_0008);
      end
      step();
    end
    idle(); step();

    // Locked burst of 8 writes against a reading CPU.
    cpu_read = 1; dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h0;
    for (int c = 0; c < 13; c++) begin
      dma_addr  = (c >= 4) ? 32'((c - 4) * 4) : 32'h0;
      dma_wdata = 32'hB000_0000 | c;
      @(negedge clk);
      if (c >= 4 && c < 12) begin
        chk("lit_burst_gnt", dma_gnt, 1);
        chk("lit_burst_stall", cpu_stall, 1);
        chk("lit_burst_owner", dma_owner, (c > 4) ? 1 : 0);
      end else if (c == 12) begin
        chk("lit_burst_end_gnt", dma_gnt, 0);
        chk("lit_burst_end_owner", dma_owner, 0);
        chk("lit_burst_end_mread", mem_read, 1);
      end
      step();
    end
    idle(); step();

    // Early unlock on beat 3.
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h40;
    @(negedge clk); chk("lit_unl_b1", dma_gnt, 1);
    step(); cpu_read = 1; dma_addr = 32'h44;
    @(negedge clk); chk("lit_unl_b2", dma_owner, 1);
    step(); dma_lock = 0; dma_addr = 32'h48;
    @(negedge clk); chk("lit_unl_b3", dma_gnt, 1);
    step();
    @(negedge clk);
    chk("lit_unl_cpu_gnt", dma_gnt, 0);
    chk("lit_unl_owner", dma_owner, 0);
    step(); idle(); step();

    // Reset during beat 2 of a read burst.
    dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 32'h24;
    step();
    @(negedge clk);
    chk("lit_mid_b2_gnt", dma_gnt, 1);
    chk("lit_mid_b1_rvalid", dma_rvalid, 1);
    #2 reset = 0; idle();
    @(negedge clk);
    chk("lit_mid_rvalid", dma_rvalid, 0);
    step(); step();
    reset = 1;
    @(negedge clk);
    chk("lit_mid_owner", dma_owner, 0);
    chk("lit_mid_rvalid2", dma_rvalid, 0);
    step();

    // Randomised traffic.
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 149) != 0);
      if (!m_stall) begin
        int op = $urandom_range(0, 3);
        cpu_read  = (op == 1 || op == 3);
        cpu_write = (op == 2);
        cpu_addr  = ($urandom & 32'hFFFF_FF00) | ($urandom & 32'hFC);
        cpu_wdata = $urandom;
      end
      dma_req   = ($urandom_range(0, 2) != 0);
      dma_we    = $urandom_range(0, 1);
      dma_lock  = ($urandom_range(0, 7) != 0);
      dma_addr  = $urandom & 32'hFC;
      dma_wdata = $urandom;
      step();
    end
    idle(); reset = 1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
